// File: rtl/usb_tx_sequencer_pkg.sv
// Shared encodings for the USB transmit sequencer: piso phase codes,
// packet command codes and sequencer state encoding.
package usb_tx_sequencer_pkg;

  localparam int REQ_TYPE_W = 3;

  typedef enum logic [REQ_TYPE_W-1:0] {
    REQ_SYNC         = 3'd0,
    REQ_PID_READ     = 3'd1,
    REQ_READ_ADDRESS = 3'd2,
    REQ_PASS_THROUGH = 3'd3,
    REQ_PID_ACK      = 3'd4,
    REQ_PID_NAK      = 3'd5
  } req_type_e;

  typedef enum logic [1:0] {
    CMD_IN   = 2'd0,
    CMD_ACK  = 2'd1,
    CMD_NAK  = 2'd2,
    CMD_DATA = 2'd3
  } cmd_type_e;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_SYNC = 3'd1,
    ST_PID  = 3'd2,
    ST_ADDR = 3'd3,
    ST_DATA = 3'd4,
    ST_GAP  = 3'd5
  } seq_state_e;

  function automatic req_type_e pid_for_cmd(input cmd_type_e c);
    case (c)
      CMD_ACK: pid_for_cmd = REQ_PID_ACK;
      CMD_NAK: pid_for_cmd = REQ_PID_NAK;
      default: pid_for_cmd = REQ_PID_READ;
    endcase
  endfunction

endpackage

// File: rtl/usb_tx_byte_counter.sv
// Counts piso_data_last pulses within one phase; terminal fires on the pulse
// that completes the target byte count. The counter never wraps.
module usb_tx_byte_counter #(
  parameter int W = 6
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clear_i,
  input  logic         tick_i,
  input  logic [W-1:0] target_i,
  output logic         terminal_o
);

  logic [W-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (!rst || clear_i) begin
      cnt_q <= '0;
    end else if (tick_i) begin
      cnt_q <= cnt_q + W'(1);
    end
  end

  assign terminal_o = tick_i && (cnt_q == target_i - W'(1));

endmodule

// File: rtl/usb_tx_sequencer.sv
// USB transmit packet sequencer driving the piso phase-request interface.
// Optional per-phase watchdog enabled by defining USB_TX_SEQ_TIMEOUT_EN.
module usb_tx_sequencer
  import usb_tx_sequencer_pkg::*;
#(
  parameter int LEN_WIDTH      = 6,
  parameter int IPG_CYCLES     = 16,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [1:0]            cmd_type,
  input  logic [LEN_WIDTH-1:0]  cmd_len,
  input  logic                  abort,
  input  logic                  piso_data_last,
  output logic                  request_serial_data,
  output logic [REQ_TYPE_W-1:0] request_serial_data_type,
  output logic                  busy,
  output logic                  done,
  output logic                  error
);

  localparam int GAP_W = (IPG_CYCLES > 0) ? $clog2(IPG_CYCLES + 1) : 1;

  seq_state_e           state_q;
  req_type_e            rtype_q;
  cmd_type_e            typ_q;
  logic [LEN_WIDTH-1:0] len_q;
  logic [GAP_W-1:0]     gap_q;
  logic                 req_q, busy_q, done_q, ready_q;

  logic                 phase_active, accept, terminal, timeout;
  logic [LEN_WIDTH-1:0] target;
  seq_state_e           succ_st;
  req_type_e            succ_type;

  assign phase_active = (state_q == ST_SYNC) || (state_q == ST_PID) ||
                        (state_q == ST_ADDR) || (state_q == ST_DATA);
  assign accept       = (state_q == ST_IDLE) && ready_q && cmd_valid;

  always_comb begin
    target    = LEN_WIDTH'(1);
    succ_st   = ST_GAP;
    succ_type = REQ_SYNC;
    case (state_q)
      ST_SYNC: begin
        if (typ_q != CMD_DATA) begin
          succ_st   = ST_PID;
          succ_type = pid_for_cmd(typ_q);
        end else if (len_q != '0) begin
          succ_st   = ST_DATA;
          succ_type = REQ_PASS_THROUGH;
        end
      end
      ST_PID: begin
        if (typ_q == CMD_IN) begin
          succ_st   = ST_ADDR;
          succ_type = REQ_READ_ADDRESS;
        end
      end
      ST_ADDR: target = LEN_WIDTH'(2);
      ST_DATA: target = len_q;
      default: ;
    endcase
  end

  usb_tx_byte_counter #(.W(LEN_WIDTH)) u_byte_counter (
    .clk        (clk),
    .rst        (rst),
    .clear_i    (!phase_active || terminal || abort || timeout),
    .tick_i     (phase_active && piso_data_last),
    .target_i   (target),
    .terminal_o (terminal)
  );

`ifdef USB_TX_SEQ_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [WD_W-1:0] wd_q;
  logic            err_q;

  assign timeout = phase_active && !abort && !piso_data_last &&
                   (wd_q == WD_W'(TIMEOUT_CYCLES - 1));

  // Watchdog restarts on phase entry (it is held clear outside active phases) and on every byte.
  always_ff @(posedge clk) begin
    if (!rst || !phase_active || piso_data_last || abort || timeout) begin
      wd_q <= '0;
    end else begin
      wd_q <= wd_q + WD_W'(1);
    end
    err_q <= rst && timeout;
  end

  assign error = err_q;
`else
  assign timeout = 1'b0;
  assign error   = 1'b0;
`endif

  // Command fields are plain data; only captured on accept.
  always_ff @(posedge clk) begin
    if (accept) begin
      typ_q <= cmd_type_e'(cmd_type);
      len_q <= cmd_len;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      rtype_q <= REQ_SYNC;
      req_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      ready_q <= (IPG_CYCLES == 0);
      gap_q   <= GAP_W'(IPG_CYCLES);
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (gap_q != '0) begin
            gap_q   <= gap_q - GAP_W'(1);
            ready_q <= (gap_q == GAP_W'(1));
          end else if (accept) begin
            state_q <= ST_SYNC;
            rtype_q <= REQ_SYNC;
            req_q   <= 1'b1;
            busy_q  <= 1'b1;
            ready_q <= 1'b0;
          end
        end
        ST_GAP: begin
          if (gap_q == '0) begin
            state_q <= ST_IDLE;
            ready_q <= 1'b1;
          end else begin
            gap_q <= gap_q - GAP_W'(1);
          end
        end
        default: begin
          // abort outranks timeout, which outranks a terminal byte
          if (abort || timeout || (terminal && succ_st == ST_GAP)) begin
            state_q <= ST_GAP;
            rtype_q <= REQ_SYNC;
            req_q   <= 1'b0;
            busy_q  <= 1'b0;
            gap_q   <= GAP_W'(IPG_CYCLES);
            done_q  <= !abort && !timeout;
          end else if (terminal) begin
            state_q <= succ_st;
            rtype_q <= succ_type;
          end
        end
      endcase
    end
  end

  assign cmd_ready                = ready_q;
  assign request_serial_data      = req_q;
  assign request_serial_data_type = rtype_q;
  assign busy                     = busy_q;
  assign done                     = done_q;

endmodule

// File: tb/tb_usb_tx_sequencer.sv
// Scoreboard bench for usb_tx_sequencer: expected piso phase codes are queued
// at command issue and popped on every byte the piso model completes.
module tb_usb_tx_sequencer;
  import usb_tx_sequencer_pkg::*;

  localparam int LW  = 6;
  localparam int IPG = 4;
  localparam int TMO = 32;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          cmd_valid = 1'b0;
  logic [1:0]    cmd_type = 2'd0;
  logic [LW-1:0] cmd_len = '0;
  logic          abort = 1'b0;
  logic          piso_data_last = 1'b0;
  logic          cmd_ready, request_serial_data, busy, done, error;
  logic [2:0]    request_serial_data_type;

  int         n_chk = 0;
  int         n_bad = 0;
  int         n_done = 0;
  logic [2:0] exp_q[$];

  usb_tx_sequencer #(.LEN_WIDTH(LW), .IPG_CYCLES(IPG), .TIMEOUT_CYCLES(TMO)) dut (
    .clk                      (clk),
    .rst                      (rst),
    .cmd_valid                (cmd_valid),
    .cmd_ready                (cmd_ready),
    .cmd_type                 (cmd_type),
    .cmd_len                  (cmd_len),
    .abort                    (abort),
    .piso_data_last           (piso_data_last),
    .request_serial_data      (request_serial_data),
    .request_serial_data_type (request_serial_data_type),
    .busy                     (busy),
    .done                     (done),
    .error                    (error)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (done) n_done++;
    if (piso_data_last && request_serial_data) begin
      if (exp_q.size() == 0) chk("sb_unexpected_byte", 32'd1, 32'd0);
      else                   chk("sb_phase_type", request_serial_data_type, exp_q.pop_front());
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_bytes(input int n);
    for (int i = 0; i < n; i++) begin
      repeat (7) tick();
      piso_data_last = 1'b1;
      tick();
      piso_data_last = 1'b0;
    end
  endtask

  task automatic wait_ready(output int n);
    n = 0;
    while (!cmd_ready && n < 64) begin
      tick();
      n++;
    end
    if (!cmd_ready) chk("ready_wait_expired", 32'd0, 32'd1);
  endtask

  task automatic send_cmd(input logic [1:0] t, input logic [LW-1:0] l);
    chk("ready_before_cmd", cmd_ready, 1);
    cmd_valid = 1'b1;
    cmd_type  = t;
    cmd_len   = l;
    tick();
    cmd_valid = 1'b0;
    chk("accept_busy", busy, 1);
    chk("accept_req", request_serial_data, 1);
    chk("accept_type", request_serial_data_type, REQ_SYNC);
  endtask

  task automatic finish_pkt(input string tag, input logic exp_done);
    int n;
    chk({tag, "_done"}, done, exp_done);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_req"}, request_serial_data, 0);
    chk({tag, "_type"}, request_serial_data_type, 0);
    wait_ready(n);
    chk({tag, "_gap_len"}, n, IPG + 1);
    chk({tag, "_ready_busy"}, busy, 0);
    chk({tag, "_sb_drain"}, exp_q.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    int n;
    int e;
    repeat (3) tick();
    chk("rst_req", request_serial_data, 0);
    chk("rst_type", request_serial_data_type, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_error", error, 0);
    chk("rst_ready", cmd_ready, 0);
    rst = 1'b1;
    wait_ready(n);

    send_cmd(CMD_ACK, '0);
    exp_q.push_back(REQ_SYNC); exp_q.push_back(REQ_PID_ACK);
    pulse_bytes(2);
    finish_pkt("ack", 1'b1);

    send_cmd(CMD_IN, '0);
    exp_q.push_back(REQ_SYNC); exp_q.push_back(REQ_PID_READ);
    exp_q.push_back(REQ_READ_ADDRESS); exp_q.push_back(REQ_READ_ADDRESS);
    pulse_bytes(3);
    chk("in_busy_before_last", busy, 1);
    chk("in_addr_type", request_serial_data_type, REQ_READ_ADDRESS);
    pulse_bytes(1);
    finish_pkt("in", 1'b1);

    send_cmd(CMD_DATA, LW'(3));
    exp_q.push_back(REQ_SYNC);
    for (int i = 0; i < 3; i++) exp_q.push_back(REQ_PASS_THROUGH);
    pulse_bytes(2);
    chk("data_type", request_serial_data_type, REQ_PASS_THROUGH);
    cmd_valid = 1'b1;
    cmd_type  = CMD_ACK;
    tick();
    chk("held_not_ready", cmd_ready, 0);
    pulse_bytes(2);
    finish_pkt("data3", 1'b1);
    tick();
    chk("held_accept_busy", busy, 1);
    chk("held_accept_type", request_serial_data_type, REQ_SYNC);
    cmd_valid = 1'b0;
    exp_q.push_back(REQ_SYNC); exp_q.push_back(REQ_PID_ACK);
    pulse_bytes(2);
    finish_pkt("held_ack", 1'b1);

    send_cmd(CMD_NAK, '0);
    exp_q.push_back(REQ_SYNC);
    pulse_bytes(1);
    chk("nak_pid_type", request_serial_data_type, REQ_PID_NAK);
    repeat (5) tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    finish_pkt("nak_abort", 1'b0);

    send_cmd(CMD_ACK, '0);
    exp_q.push_back(REQ_SYNC); exp_q.push_back(REQ_PID_ACK);
    pulse_bytes(1);
    repeat (3) tick();
    abort = 1'b1;
    piso_data_last = 1'b1;
    tick();
    abort = 1'b0;
    piso_data_last = 1'b0;
    finish_pkt("abort_prio", 1'b0);

    send_cmd(CMD_DATA, '0);
    exp_q.push_back(REQ_SYNC);
    pulse_bytes(1);
    finish_pkt("data0", 1'b1);

    send_cmd(CMD_IN, '0);
    exp_q.push_back(REQ_SYNC); exp_q.push_back(REQ_PID_READ);
    exp_q.push_back(REQ_READ_ADDRESS);
    pulse_bytes(3);
    chk("mid_addr_type", request_serial_data_type, REQ_READ_ADDRESS);
    rst = 1'b0;
    tick();
    chk("midrst_req", request_serial_data, 0);
    chk("midrst_type", request_serial_data_type, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_done", done, 0);
    chk("midrst_ready", cmd_ready, 0);
    chk("midrst_sb_drain", exp_q.size(), 0);
    rst = 1'b1;
    wait_ready(n);
    send_cmd(CMD_ACK, '0);
    exp_q.push_back(REQ_SYNC); exp_q.push_back(REQ_PID_ACK);
    pulse_bytes(2);
    finish_pkt("post_rst", 1'b1);

`ifdef USB_TX_SEQ_TIMEOUT_EN
    send_cmd(CMD_ACK, '0);
    n = 0;
    while (!error && n < 100) begin
      tick();
      n++;
    end
    chk("tmo_cycles", n, TMO);
    chk("tmo_error", error, 1);
    finish_pkt("timeout", 1'b0);
`else
    send_cmd(CMD_ACK, '0);
    e = 0;
    repeat (40) begin
      tick();
      e = e | int'(error);
    end
    chk("no_tmo_error", e, 0);
    chk("no_tmo_busy", busy, 1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    finish_pkt("no_tmo_abort", 1'b0);
`endif

    chk("done_total", n_done, 6);
    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
